regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Shares the single write port of the 32×32 register file between several writeback requesters (ALU, load unit, multiplier) and tracks in-flight destinations in a busy scoreboard. Exactly one requester is granted per cycle and its write is registered toward the register file port. Issue logic reads the scoreboard to stall on read-after-write hazards. The block sits between the execution units' writeback stage and the register file.

## Interface
- NUM_REQ, 3, number of writeback requesters (2..8)
- iClk  in  1  clock
- iRstN  in  1  reset, asynchronous, active-low
- iReqValid  in  NUM_REQ  requester i has a write pending
- iReqRd  in  NUM_REQ*5  destination address, requester i in bits [5i+4:5i]
- iReqData  in  NUM_REQ*32  write data, requester i in bits [32i+31:32i]
- oReqReady  out  NUM_REQ  one-hot grant; transfer when valid&ready
- iIssueValid  in  1  an instruction with a destination issues this cycle
- iIssueRd  in  5  its destination address
- iFlush  in  1  clears the scoreboard and the output stage
- oWriteEn  out  1  to register file write enable
- oRdAddr  out  5  to register file destination address
- oWriteData  out  32  to register file write data
- oBusy  out  32  scoreboard; bit r set = write to xr outstanding

## Operation
- Grant: among asserted iReqValid, one index is selected (policy per Configuration); oReqReady is that index one-hot, combinational from iReqValid and the arbitration state; all zero when no valid.
- Requester holds valid/rd/data stable until ready; ungranted requesters wait, no drop.
- Accepted transfer loads the output stage: oWriteEn<=1, oRdAddr<=rd, oWriteData<=data; with no transfer, oWriteEn<=0 and addr/data hold.
- rd=0 transfer: accepted (ready asserted, counts for arbitration) but oWriteEn<=0.
- Scoreboard set: iIssueValid with iIssueRd≠0 sets oBusy[iIssueRd] at next edge.
- Scoreboard clear: accepted transfer clears oBusy[rd] at the same edge the output stage loads.
- Set and clear of the same r in one cycle: set wins (new producer outstanding).
- oBusy[0] is constant 0.
- iFlush: at next edge oBusy<=0, oWriteEn<=0; grant is still issued that cycle but the write is discarded. Flush overrides a simultaneous issue set.
- Two requesters with the same rd: served in grant order; busy clears on the first, which issue logic must not rely on (one producer per rd in flight is an issuer invariant).

## Timing
- Reset: oWriteEn=0, oRdAddr=0, oWriteData=0, oBusy=0, round-robin pointer=0; oReqReady follows iReqValid combinationally.
- Latency: valid&ready at edge N → oWriteEn high in cycle N+1; register file writes at edge N+1.
- oBusy updates at the edge after the issue or transfer.
- Throughput: one write per cycle, sustained.
- Reset asserted mid-operation: all state cleared immediately; pending requests re-arbitrate from pointer 0 after release.

## Configuration
- RR_ARB_EN defined: round-robin. Pointer p starts at 0; the search starts at p and wraps modulo NUM_REQ; after a grant to index g, p<=(g+1) mod NUM_REQ; p holds when there is no grant.
- RR_ARB_EN undefined: fixed priority, lowest index wins; no pointer register.

## Structure
- Shared package: REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32, and the writeback request struct typedef (valid, rd, data).
- Sub-module rr_arbiter (NUM_REQ; request vector in, one-hot grant out, pointer internal, fixed priority when RR_ARB_EN undefined). The scoreboard and the output stage stay in the top.

## Test plan
- Reset release, no valid → oReqReady=0, oWriteEn=0, oBusy=0.
- Single req0 rd=5 data=0xDEADBEEF → ready0 same cycle; next cycle oWriteEn=1, oRdAddr=5, oWriteData=0xDEADBEEF.
- All three valid for 3 cycles with RR_ARB_EN → grants 0,1,2; undefined → 0,0,0.
- Issue rd=7 → oBusy[7]=1 next cycle; later transfer rd=7 → oBusy[7]=0; issue rd=7 in the same cycle as the clearing transfer → oBusy[7] stays 1.
- Req rd=0 data=0x1 → ready asserted, oWriteEn stays 0; issue rd=0 → oBusy=0.
- oBusy=0x00F0 then iFlush with simultaneous req0 → next cycle oBusy=0, oWriteEn=0.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared widths and writeback request record for regfile_wb_arbiter
package regfile_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - one-hot grant arbiter; round-robin when RR_ARB_EN is defined, else fixed priority
module rr_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
`ifdef RR_ARB_EN
  input  logic               iClk,
  input  logic               iRstN,
`endif
  input  logic [NUM_REQ-1:0] iReq,
  output logic [NUM_REQ-1:0] oGrant
);

  logic found;

`ifdef RR_ARB_EN
  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] grantIdx;

  // Search from ptr upward first, then wrap to the low indices below ptr.
  always_comb begin
    oGrant   = '0;
    grantIdx = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && iReq[i] && (PTR_W'(i) >= ptr)) begin
        found     = 1'b1;
        grantIdx  = PTR_W'(i);
        oGrant[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && iReq[i]) begin
        found     = 1'b1;
        grantIdx  = PTR_W'(i);
        oGrant[i] = 1'b1;
      end
    end
  end

  // Pointer moves just past the winner; it holds when nobody is granted.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (grantIdx == PTR_W'(NUM_REQ - 1)) ? '0 : grantIdx + PTR_W'(1);
    end
  end
`else
  // Lowest asserted index wins.
  always_comb begin
    oGrant = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && iReq[i]) begin
        found     = 1'b1;
        oGrant[i] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - writeback port arbiter with busy scoreboard; RR_ARB_EN selects round-robin
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic                           iClk,
  input  logic                           iRstN,
  input  logic [NUM_REQ-1:0]             iReqValid,
  input  logic [NUM_REQ*REG_ADDR_W-1:0]  iReqRd,
  input  logic [NUM_REQ*REG_DATA_W-1:0]  iReqData,
  output logic [NUM_REQ-1:0]             oReqReady,
  input  logic                           iIssueValid,
  input  logic [REG_ADDR_W-1:0]          iIssueRd,
  input  logic                           iFlush,
  output logic                           oWriteEn,
  output logic [REG_ADDR_W-1:0]          oRdAddr,
  output logic [REG_DATA_W-1:0]          oWriteData,
  output logic [NUM_REGS-1:0]            oBusy
);

  wb_req_t             req [NUM_REQ];
  wb_req_t             sel;
  logic [NUM_REQ-1:0]  grant;
  logic                xfer;
  logic [NUM_REGS-1:0] busyNext;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) uArb (
`ifdef RR_ARB_EN
    .iClk  (iClk),
    .iRstN (iRstN),
`endif
    .iReq  (iReqValid),
    .oGrant(grant)
  );

  assign oReqReady = grant;

  // Unpack the flat requester buses into per-requester records.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req[i].valid = iReqValid[i];
      req[i].rd    = iReqRd[i*REG_ADDR_W +: REG_ADDR_W];
      req[i].data  = iReqData[i*REG_DATA_W +: REG_DATA_W];
    end
  end

  // Grant is one-hot, so OR-ing the masked records yields the winner.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel = sel | req[i];
      end
    end
  end

  assign xfer = sel.valid;

  // Scoreboard next state: clear on retire, then set on issue so a new producer wins; flush wipes all.
  always_comb begin
    busyNext = oBusy;
    if (xfer) begin
      busyNext[sel.rd] = 1'b0;
    end
    if (iIssueValid && (iIssueRd != '0)) begin
      busyNext[iIssueRd] = 1'b1;
    end
    busyNext[0] = 1'b0;
    if (iFlush) begin
      busyNext = '0;
    end
  end

  // Scoreboard register.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      oBusy <= '0;
    end else begin
      oBusy <= busyNext;
    end
  end

  // Output stage toward the register file; x0 writes and flushed writes never assert the enable.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      oWriteEn   <= 1'b0;
      oRdAddr    <= '0;
      oWriteData <= '0;
    end else if (iFlush) begin
      oWriteEn <= 1'b0;
    end else if (xfer) begin
      oWriteEn   <= (sel.rd != '0);
      oRdAddr    <= sel.rd;
      oWriteData <= sel.data;
    end else begin
      oWriteEn <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed scoreboard bench for regfile_wb_arbiter; honours RR_ARB_EN
module tb_regfile_wb_arbiter;

  logic        iClk;
  logic        iRstN;
  logic [2:0]  iReqValid;
  logic [14:0] iReqRd;
  logic [95:0] iReqData;
  logic [2:0]  oReqReady;
  logic        iIssueValid;
  logic [4:0]  iIssueRd;
  logic        iFlush;
  logic        oWriteEn;
  logic [4:0]  oRdAddr;
  logic [31:0] oWriteData;
  logic [31:0] oBusy;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] expBusy;
  int          nAsserts;
  int          nFails;

  regfile_wb_arbiter #(.NUM_REQ(3)) dut (
    .iClk       (iClk),
    .iRstN      (iRstN),
    .iReqValid  (iReqValid),
    .iReqRd     (iReqRd),
    .iReqData   (iReqData),
    .oReqReady  (oReqReady),
    .iIssueValid(iIssueValid),
    .iIssueRd   (iIssueRd),
    .iFlush     (iFlush),
    .oWriteEn   (oWriteEn),
    .oRdAddr    (oRdAddr),
    .oWriteData (oWriteData),
    .oBusy      (oBusy)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, check the combinational grant, then check the registered result.
  task automatic step(input logic [2:0] v,
                      input logic [4:0] rd0, input logic [4:0] rd1, input logic [4:0] rd2,
                      input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                      input logic iv, input logic [4:0] ird, input logic fl,
                      input logic [2:0] expRdy, input string tag);
    logic [4:0]  rds[3];
    logic [31:0] ds[3];
    logic        hit;
    logic [4:0]  grd;
    logic [31:0] gd;
    exp_t        e;
    rds = '{rd0, rd1, rd2};
    ds  = '{d0, d1, d2};
    iReqValid   = v;
    iReqRd      = {rd2, rd1, rd0};
    iReqData    = {d2, d1, d0};
    iIssueValid = iv;
    iIssueRd    = ird;
    iFlush      = fl;
    #1;
    check({29'b0, oReqReady}, {29'b0, expRdy}, {tag, ".ready"});
    hit = 1'b0;
    grd = '0;
    gd  = '0;
    for (int k = 0; k < 3; k++) begin
      if (expRdy[k]) begin
        hit = 1'b1;
        grd = rds[k];
        gd  = ds[k];
      end
    end
    e.we = 1'b0;
    e.rd = '0;
    e.data = '0;
    if (hit && !fl) begin
      e.we   = (grd != 5'd0);
      e.rd   = grd;
      e.data = gd;
    end
    expQ.push_back(e);
    if (fl) begin
      expBusy = '0;
    end else begin
      if (hit) expBusy[grd] = 1'b0;
      if (iv && ird != 5'd0) expBusy[ird] = 1'b1;
    end
    @(posedge iClk);
    @(negedge iClk);
    if (expQ.size() == 0) begin
      check(32'd1, 32'd0, {tag, ".queue_empty"});
    end else begin
      e = expQ.pop_front();
      check({31'b0, oWriteEn}, {31'b0, e.we}, {tag, ".we"});
      if (e.we) begin
        check({27'b0, oRdAddr}, {27'b0, e.rd}, {tag, ".addr"});
        check(oWriteData, e.data, {tag, ".data"});
      end
    end
    check(oBusy, expBusy, {tag, ".busy"});
  endtask

  initial begin
    nAsserts    = 0;
    nFails      = 0;
    expBusy     = '0;
    iRstN       = 1'b0;
    iReqValid   = '0;
    iReqRd      = '0;
    iReqData    = '0;
    iIssueValid = 1'b0;
    iIssueRd    = '0;
    iFlush      = 1'b0;
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    iRstN = 1'b1;
    #1;
    check({29'b0, oReqReady}, 32'd0, "reset.ready");
    check({31'b0, oWriteEn}, 32'd0, "reset.we");
    check({27'b0, oRdAddr}, 32'd0, "reset.addr");
    check(oWriteData, 32'd0, "reset.data");
    check(oBusy, 32'd0, "reset.busy");

    step(3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 3'b001, "single");

    // Asynchronous reset while the output stage holds a write.
    iReqValid = '0;
    iRstN = 1'b0;
    #1;
    check({31'b0, oWriteEn}, 32'd0, "midreset.we");
    check({27'b0, oRdAddr}, 32'd0, "midreset.addr");
    check(oWriteData, 32'd0, "midreset.data");
    @(negedge iClk);
    iRstN = 1'b1;
    expBusy = '0;

`ifdef RR_ARB_EN
    step(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 1'b0, 5'd0, 1'b0, 3'b001, "all3.c0");
    step(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 1'b0, 5'd0, 1'b0, 3'b010, "all3.c1");
    step(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 1'b0, 5'd0, 1'b0, 3'b100, "all3.c2");
`else
    step(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 1'b0, 5'd0, 1'b0, 3'b001, "all3.c0");
    step(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 1'b0, 5'd0, 1'b0, 3'b001, "all3.c1");
    step(3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 1'b0, 5'd0, 1'b0, 3'b001, "all3.c2");
    step(3'b110, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 1'b0, 5'd0, 1'b0, 3'b010, "drain.c3");
    step(3'b100, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 1'b0, 5'd0, 1'b0, 3'b100, "drain.c4");
`endif

    step(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd7, 1'b0, 3'b000, "issue7");
    step(3'b010, 5'd0, 5'd7, 5'd0, 32'h0, 32'hAAAA, 32'h0, 1'b0, 5'd0, 1'b0, 3'b010, "retire7");
    step(3'b100, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'hBBBB, 1'b1, 5'd7, 1'b0, 3'b100, "setwins7");

    step(3'b001, 5'd0, 5'd0, 5'd0, 32'h1, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 3'b001, "rd0.write");
    step(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd0, 1'b0, 3'b000, "rd0.issue");

    step(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd4, 1'b0, 3'b000, "issue4");
    step(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd5, 1'b0, 3'b000, "issue5");
    step(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd6, 1'b0, 3'b000, "issue6");
    check(oBusy, 32'h0000_00F0, "busy.f0");
    step(3'b001, 5'd9, 5'd0, 5'd0, 32'h1234, 32'h0, 32'h0, 1'b1, 5'd3, 1'b1, 3'b001, "flush");
    step(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 3'b000, "idle");

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
